// File: rtl/neuron_sched_pkg.sv
// Shared definitions for the neuron core timestep scheduler: command opcodes,
// FSM state encoding and the neuron-block count helper.
package neuron_sched_pkg;

  // Command opcodes presented on cmd_op_o; 0 means no command.
  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_INTEG = 2'd1;
  localparam logic [1:0] OP_FIRE  = 2'd2;

  // Timestep sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INTEG = 2'd1,
    S_FIRE  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  // Number of neuron blocks; neurons must be an exact multiple of blk.
  function automatic int unsigned calc_nblk(input int unsigned neurons, input int unsigned blk);
    return neurons / blk;
  endfunction

endpackage

// File: rtl/neuron_sched_fifo.sv
// Synchronous spike queue. Head entry is visible combinationally on rdata.
// A push while full is dropped (no bypass even when popping in the same cycle);
// a pop while empty is ignored.
module neuron_sched_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/neuron_core_scheduler.sv
// Timestep sequencer for neuron_core_256x256. Queues axon spike events and, on each
// tick, issues one INTEG command per neuron block for every spike queued before the
// tick, then sweeps all blocks with FIRE commands and pulses done_o.
// Optional build macro NEURON_SCHED_PERF_EN adds perf_cycles_o / perf_spikes_o.
module neuron_core_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int unsigned AXON_W     = 8,
  parameter int unsigned NEURONS    = 256,
  parameter int unsigned BLK        = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tick_i,
  input  logic                               spk_valid_i,
  input  logic [AXON_W-1:0]                  spk_axon_i,
  output logic                               spk_ready_o,
  output logic                               cmd_valid_o,
  output logic [1:0]                         cmd_op_o,
  output logic [AXON_W-1:0]                  cmd_axon_o,
  output logic [$clog2(NEURONS/BLK)-1:0]     cmd_nblk_o,
  input  logic                               cmd_ready_i,
  input  logic                               ovr_clr_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level_o
`ifdef NEURON_SCHED_PERF_EN
  ,
  output logic [15:0]                        perf_cycles_o,
  output logic [15:0]                        perf_spikes_o
`endif
);

  localparam int unsigned NBLK   = calc_nblk(NEURONS, BLK);
  localparam int unsigned NBLK_W = $clog2(NBLK);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NBLK_W-1:0] LAST_BLK = NBLK_W'(NBLK - 1);

  sched_state_e      state;
  logic [LVL_W-1:0]  drain_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [AXON_W-1:0] fifo_head;
  logic              xfer;
  logic              last_blk;

  assign spk_ready_o = ~fifo_full;
  assign fifo_push   = spk_valid_i & ~fifo_full;
  assign xfer        = cmd_valid_o & cmd_ready_i;
  assign last_blk    = (cmd_nblk_o == LAST_BLK);
  // The head spike leaves the queue only once every block has integrated it.
  assign fifo_pop    = xfer & (state == S_INTEG) & last_blk & ~fifo_empty;
  // Head stays put for the whole INTEG sweep, so it can drive the axon field directly.
  assign cmd_axon_o  = (cmd_valid_o && cmd_op_o == OP_INTEG) ? fifo_head : '0;

  neuron_sched_fifo #(
    .WIDTH (AXON_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (spk_axon_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  // Timestep FSM with registered command, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      cmd_valid_o <= 1'b0;
      cmd_op_o    <= OP_NONE;
      cmd_nblk_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tick_i) begin
            // Snapshot the occupancy: later arrivals wait for the next tick.
            drain_cnt   <= fifo_level_o;
            busy_o      <= 1'b1;
            cmd_valid_o <= 1'b1;
            cmd_nblk_o  <= '0;
            if (fifo_level_o != '0) begin
              state    <= S_INTEG;
              cmd_op_o <= OP_INTEG;
            end else begin
              state    <= S_FIRE;
              cmd_op_o <= OP_FIRE;
            end
          end
        end
        S_INTEG: begin
          if (xfer) begin
            if (last_blk) begin
              cmd_nblk_o <= '0;
              drain_cnt  <= drain_cnt - 1'b1;
              if (drain_cnt == LVL_W'(1)) begin
                state    <= S_FIRE;
                cmd_op_o <= OP_FIRE;
              end
            end else begin
              cmd_nblk_o <= cmd_nblk_o + 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (xfer) begin
            if (last_blk) begin
              cmd_nblk_o  <= '0;
              cmd_valid_o <= 1'b0;
              cmd_op_o    <= OP_NONE;
              state       <= S_DONE;
              done_o      <= 1'b1;
            end else begin
              cmd_nblk_o <= cmd_nblk_o + 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (tick_i && state != S_IDLE) begin
      overrun_o <= 1'b1;
    end else if (ovr_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

`ifdef NEURON_SCHED_PERF_EN
  logic [15:0] cyc_cnt;
  logic [15:0] spk_cnt;

  // Count cycles of the running timestep (tick cycle = 1) and publish totals at done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt       <= '0;
      spk_cnt       <= '0;
      perf_cycles_o <= '0;
      perf_spikes_o <= '0;
    end else begin
      if (state == S_IDLE && tick_i) begin
        cyc_cnt <= 16'd1;
        spk_cnt <= 16'(fifo_level_o);
      end else if (state != S_IDLE && cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (state == S_DONE) begin
        // Include the done cycle itself in the total.
        perf_cycles_o <= (cyc_cnt == 16'hFFFF) ? 16'hFFFF : cyc_cnt + 16'd1;
        perf_spikes_o <= spk_cnt;
      end
    end
  end
`endif

endmodule
